// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction fetch stage with a DEPTH-entry fetch queue. PC generation runs
// ahead of decode and talks to instruction memory over a req/gnt/rvalid
// handshake with at most one request outstanding. A taken branch/jump
// (is_bj) flushes the queue, reloads the PC and marks any in-flight response
// as stale so that it is discarded when it returns.
//
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   : a misaligned fetch_pc produces one marker entry
//               (out_misalign=1, ir=0) and the fetcher halts until the next
//               redirect.
//   undefined : redirect targets are forced word aligned, out_misalign is 0.
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        synchronous active-high reset, beats every other input
//   is_bj        redirect request (taken branch/jump)
//   bj_addr      redirect target
//   imem_req     fetch request valid
//   imem_addr    fetch address (current fetch_pc)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  response valid
//   imem_rdata   instruction word
//   out_valid    queue head valid
//   out_ready    decode accepts the head
//   ia           head instruction address (0 when empty)
//   ia_add4      head address + 4, modulo 2^XLEN (0 when empty)
//   ir           head instruction (0 when empty)
//   out_misalign head is a misaligned-fetch marker
// -----------------------------------------------------------------------------
module if_fetch_queue #(
   parameter int              XLEN       = 32,
   parameter int              DEPTH      = 4,
   parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            is_bj,
   input  logic [XLEN-1:0] bj_addr,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ia,
   output logic [XLEN-1:0] ia_add4,
   output logic [XLEN-1:0] ir,
   output logic            out_misalign
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;
`ifdef IF_MISALIGN_TRAP_EN
   localparam logic [1:0] ST_HALT = 2'd3;
`endif

   logic [1:0]      state_reg,    state_next;
   logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
   logic [XLEN-1:0] req_addr_reg, req_addr_next;
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     count_reg;

   // queue storage, read combinationally so a push is visible next cycle
   logic [XLEN-1:0] ia_mem [DEPTH];
   logic [XLEN-1:0] ir_mem [DEPTH];

   logic            req_int;
   logic            push_en;
   logic [XLEN-1:0] push_ia;
   logic [XLEN-1:0] push_ir;
   logic            pop_en;
   logic            has_space;
   logic            head_valid;
   logic [XLEN-1:0] bj_target;

`ifdef IF_MISALIGN_TRAP_EN
   logic            mis_mem [DEPTH];
   logic            push_mis;
   assign bj_target = bj_addr;
`else
   // without the trap a misaligned target cannot be represented, so it is
   // silently word aligned
   assign bj_target = bj_addr & ~XLEN'(3);
`endif

   // only REQ issues or self-pushes, and nothing is outstanding there, so the
   // count+outstanding<DEPTH rule reduces to a plain occupancy test
   assign has_space  = count_reg < FULL_COUNT;
   assign head_valid = (count_reg != '0) && !reset;
   assign pop_en     = head_valid && out_ready;

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      req_addr_next = req_addr_reg;
      req_int       = 1'b0;
      push_en       = 1'b0;
      push_ia       = req_addr_reg;
      push_ir       = imem_rdata;
`ifdef IF_MISALIGN_TRAP_EN
      push_mis      = 1'b0;
`endif

      case (state_reg)
         ST_REQ: begin
            if (has_space) begin
`ifdef IF_MISALIGN_TRAP_EN
               if (fetch_pc_reg[1:0] != 2'b00) begin
                  push_en    = 1'b1;
                  push_ia    = fetch_pc_reg;
                  push_ir    = '0;
                  push_mis   = 1'b1;
                  state_next = ST_HALT;
               end else
`endif
               begin
                  req_int = 1'b1;
                  if (imem_gnt) begin
                     req_addr_next = fetch_pc_reg;
                     fetch_pc_next = fetch_pc_reg + XLEN'(4);
                     state_next    = ST_WAIT;
                  end
               end
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               push_en    = 1'b1;
               state_next = ST_REQ;
            end
         end
         ST_DROP: begin
            if (imem_rvalid) begin
               state_next = ST_REQ;
            end
         end
`ifdef IF_MISALIGN_TRAP_EN
         ST_HALT: begin
            state_next = ST_HALT;
         end
`endif
         default: begin
            state_next = ST_REQ;
         end
      endcase

      // redirect overrides push, pop and grant; whichever response is still
      // owed by memory becomes the single stale one
      if (is_bj) begin
         push_en       = 1'b0;
         fetch_pc_next = bj_target;
         case (state_reg)
            ST_REQ:  state_next = (req_int && imem_gnt) ? ST_DROP : ST_REQ;
            ST_WAIT: state_next = imem_rvalid ? ST_REQ : ST_DROP;
            // the stale response arriving now is consumed by this cycle, so
            // staying in DROP would wait for a response that never comes
            ST_DROP: state_next = imem_rvalid ? ST_REQ : ST_DROP;
            default: state_next = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_REQ;
         fetch_pc_reg <= RESET_ADDR;
         req_addr_reg <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         req_addr_reg <= req_addr_next;
         if (is_bj) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push_en) begin
               wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_en) begin
               rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_en, pop_en})
               2'b10:   count_reg <= count_reg + (AW+1)'(1);
               2'b01:   count_reg <= count_reg - (AW+1)'(1);
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_en && !reset) begin
         ia_mem[wr_ptr_reg] <= push_ia;
         ir_mem[wr_ptr_reg] <= push_ir;
`ifdef IF_MISALIGN_TRAP_EN
         mis_mem[wr_ptr_reg] <= push_mis;
`endif
      end
   end

   assign imem_req  = req_int && !reset;
   assign imem_addr = fetch_pc_reg;
   assign out_valid = head_valid;
   assign ia        = head_valid ? ia_mem[rd_ptr_reg] : '0;
   assign ia_add4   = head_valid ? ia_mem[rd_ptr_reg] + XLEN'(4) : '0;
   assign ir        = head_valid ? ir_mem[rd_ptr_reg] : '0;
`ifdef IF_MISALIGN_TRAP_EN
   assign out_misalign = head_valid && mis_mem[rd_ptr_reg];
`else
   assign out_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Directed bench for if_fetch_queue. A memory model grants requests while a
// grant budget lasts and answers after mem_lat cycles with addr^A5A5_0000.
// Stimulus pushes the hand-derived expected head entries into exp_q; a monitor
// pops and compares on every out_valid && out_ready cycle.
// -----------------------------------------------------------------------------
module tb_if_fetch_queue;

   localparam logic [31:0] K          = 32'hA5A5_0000;
   localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

   logic        clk         = 1'b0;
   logic        reset       = 1'b1;
   logic        is_bj       = 1'b0;
   logic [31:0] bj_addr     = '0;
   logic        imem_gnt    = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata  = '0;
   logic        out_ready   = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        out_valid;
   logic [31:0] ia;
   logic [31:0] ia_add4;
   logic [31:0] ir;
   logic        out_misalign;

   typedef struct {
      logic [31:0] ia;
      logic [31:0] add4;
      logic [31:0] ir;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int errors = 0;
   int checks = 0;

   int          mem_budget = 0;
   int          mem_lat    = 1;
   bit          mem_busy   = 1'b0;
   int          mem_cnt    = 0;
   logic [31:0] mem_pend   = '0;

   if_fetch_queue #(
      .XLEN       (32),
      .DEPTH      (4),
      .RESET_ADDR (RESET_ADDR)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .is_bj        (is_bj),
      .bj_addr      (bj_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .ia           (ia),
      .ia_add4      (ia_add4),
      .ir           (ir),
      .out_misalign (out_misalign)
   );

   always #5 clk = ~clk;

   // memory model: decides the handshake for the coming rising edge
   always @(negedge clk) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (mem_busy) begin
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_pend ^ K;
            mem_busy    = 1'b0;
         end else begin
            mem_cnt = mem_cnt - 1;
         end
      end else if (imem_req && mem_budget > 0) begin
         imem_gnt   = 1'b1;
         mem_pend   = imem_addr;
         mem_budget = mem_budget - 1;
         mem_busy   = 1'b1;
         mem_cnt    = mem_lat - 1;
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_txn: got ia=%h ir=%h, required no output", ia, ir);
         end else begin
            mon_e = exp_q.pop_front();
            if (ia !== mon_e.ia || ia_add4 !== mon_e.add4 || ir !== mon_e.ir ||
                out_misalign !== mon_e.mis) begin
               errors++;
               $display("FAIL txn: got ia=%h ia_add4=%h ir=%h mis=%b, required ia=%h ia_add4=%h ir=%h mis=%b",
                        ia, ia_add4, ir, out_misalign, mon_e.ia, mon_e.add4, mon_e.ir, mon_e.mis);
            end else begin
               $display("txn ia=%h ia_add4=%h ir=%h mis=%b ok", ia, ia_add4, ir, out_misalign);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic exp_word(input logic [31:0] a);
      exp_q.push_back('{a, a + 32'd4, a ^ K, 1'b0});
   endtask

   task automatic exp_raw(input logic [31:0] a, input logic [31:0] a4,
                          input logic [31:0] w, input logic m);
      exp_q.push_back('{a, a4, w, m});
   endtask

   // drive point: just after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // observe point: just after the falling edge
   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         look();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d entries outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (4) look();
   endtask

   task automatic wait_gnt(input string name, input logic [31:0] addr);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         look();
         if (imem_gnt && imem_addr == addr) found = 1'b1;
      end
      check(name, {31'd0, found}, 32'd1);
   endtask

   initial begin
      // reset state
      reset     = 1'b1;
      out_ready = 1'b1;
      repeat (3) step();
      look();
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_ia", ia, 32'd0);
      check("rst_ia_add4", ia_add4, 32'd0);
      check("rst_ir", ir, 32'd0);
      check("rst_misalign", {31'd0, out_misalign}, 32'd0);

      // in-order fetch from RESET_ADDR and minimum latency
      step();
      reset      = 1'b0;
      mem_lat    = 1;
      mem_budget = 4;
      exp_word(32'h0);
      exp_word(32'h4);
      exp_word(32'h8);
      exp_word(32'hC);
      wait_gnt("first_gnt", RESET_ADDR);
      look();
      check("lat_n1_valid", {31'd0, out_valid}, 32'd0);
      look();
      check("lat_n2_valid", {31'd0, out_valid}, 32'd1);
      drain("seq");

      // back-pressure: queue fills to DEPTH and requests stop
      step();
      out_ready  = 1'b0;
      mem_budget = 10;
      exp_word(32'h10);
      exp_word(32'h14);
      exp_word(32'h18);
      exp_word(32'h1C);
      repeat (14) look();
      check("full_imem_req", {31'd0, imem_req}, 32'd0);
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      check("full_head_ia", ia, 32'h10);
      check("full_grants", 32'(10 - mem_budget), 32'd4);
      step();
      mem_budget = 0;
      out_ready  = 1'b1;
      drain("full");

      // redirect in the second cycle of a 5-cycle wait
      step();
      mem_lat    = 5;
      mem_budget = 1;
      wait_gnt("slow_gnt", 32'h20);
      step();
      step();
      is_bj      = 1'b1;
      bj_addr    = 32'h100;
      mem_lat    = 1;
      mem_budget = 2;
      exp_word(32'h100);
      exp_word(32'h104);
      step();
      is_bj = 1'b0;
      look();
      check("redir_out_valid", {31'd0, out_valid}, 32'd0);
      check("redir_drop_req", {31'd0, imem_req}, 32'd0);
      drain("stale");

      // redirect coinciding with rvalid and a pop
      step();
      out_ready  = 1'b0;
      mem_budget = 3;
      wait_gnt("fill_gnt", 32'h110);
      step();
      is_bj     = 1'b1;
      bj_addr   = 32'h200;
      out_ready = 1'b1;
      exp_word(32'h108);
      look();
      check("bj_pop_valid", {31'd0, out_valid}, 32'd1);
      step();
      is_bj      = 1'b0;
      mem_budget = 2;
      exp_word(32'h200);
      exp_word(32'h204);
      look();
      check("bj_flush_valid", {31'd0, out_valid}, 32'd0);
      check("bj_next_req", {31'd0, imem_req}, 32'd1);
      check("bj_next_addr", imem_addr, 32'h200);
      drain("bj_rvalid");

      // reset in the middle of a wait; the late response must be ignored
      step();
      mem_lat    = 5;
      mem_budget = 1;
      wait_gnt("pre_rst_gnt", 32'h208);
      step();
      step();
      reset      = 1'b1;
      mem_lat    = 1;
      mem_budget = 1;
      exp_word(RESET_ADDR);
      look();
      check("mid_rst_req", {31'd0, imem_req}, 32'd0);
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_ia", ia, 32'd0);
      step();
      reset = 1'b0;
      look();
      check("post_rst_req", {31'd0, imem_req}, 32'd1);
      check("post_rst_addr", imem_addr, RESET_ADDR);
      drain("rst");

      // address wrap
      step();
      is_bj      = 1'b1;
      bj_addr    = 32'hFFFF_FFF8;
      mem_budget = 0;
      step();
      is_bj      = 1'b0;
      mem_budget = 3;
      exp_word(32'hFFFF_FFF8);
      exp_raw(32'hFFFF_FFFC, 32'h0000_0000, 32'h5A5A_FFFC, 1'b0);
      exp_word(32'h0);
      drain("wrap");

      // misaligned redirect target
      step();
      is_bj      = 1'b1;
      bj_addr    = 32'h102;
      mem_budget = 0;
      step();
      is_bj = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      mem_budget = 2;
      exp_raw(32'h102, 32'h106, 32'h0, 1'b1);
      drain("misalign");
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_grants", 32'(mem_budget), 32'd2);
`else
      mem_budget = 2;
      exp_word(32'h100);
      exp_word(32'h104);
      drain("align");
      check("align_next_addr", imem_addr, 32'h108);
`endif
      step();
      is_bj      = 1'b1;
      bj_addr    = 32'h200;
      mem_budget = 0;
      step();
      is_bj      = 1'b0;
      mem_budget = 2;
      exp_word(32'h200);
      exp_word(32'h204);
      drain("resume");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
